// File: rtl/cpu_pkg.sv
// Shared CPU definitions: muldiv opcodes, muldiv FSM states and the default datapath width.
// Optional feature macro: MULDIV_SIGNED_EN enables the signed opcodes OP_MULS / OP_DIVS.
package cpu_pkg;

   localparam int WIDTH_DEFAULT = 16;

   localparam logic [3:0] OP_MUL  = 4'hC;
   localparam logic [3:0] OP_DIV  = 4'hD;
   localparam logic [3:0] OP_MULS = 4'hE;
   localparam logic [3:0] OP_DIVS = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   // Signed opcodes only count as muldiv work when the signed feature is built in
   function automatic logic is_muldiv_op(input logic [3:0] opcode);
`ifdef MULDIV_SIGNED_EN
      return (opcode == OP_MUL) || (opcode == OP_DIV) ||
             (opcode == OP_MULS) || (opcode == OP_DIVS);
`else
      return (opcode == OP_MUL) || (opcode == OP_DIV);
`endif
   endfunction

   function automatic logic is_signed_op(input logic [3:0] opcode);
`ifdef MULDIV_SIGNED_EN
      return (opcode == OP_MULS) || (opcode == OP_DIVS);
`else
      return (opcode == 4'hX) && 1'b0;
`endif
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: add-shift for multiply, subtract-restore for divide.
module muldiv_step #(
   parameter int WIDTH = 16
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // Divide keeps remainder < divisor, so the trial difference always fits in WIDTH bits
   always_comb begin
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
      shifted = {hi_in, lo_in[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - operand;
      hi_out  = sum[WIDTH:1];
      lo_out  = {sum[0], lo_in[WIDTH-1:1]};
      if (is_div) begin
         if (shifted >= {1'b0, operand}) begin
            hi_out = diff;
            lo_out = {lo_in[WIDTH-2:0], 1'b1};
         end else begin
            hi_out = shifted[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit; freezes ID/EX and IF/ID while an operation runs.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULS/DIVS via magnitude + sign fix-up).
module ex_muldiv_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rest_n,
   input  logic             flush,
   input  logic             op_valid_in,
   input  logic [3:0]       opcode_in,
   input  logic [WIDTH-1:0] src1_in,
   input  logic [WIDTH-1:0] src2_in,
   input  logic [WIDTH-1:0] rd_in,
   output logic             freeze_out,
   output logic             result_valid,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] rd_out,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   muldiv_state_e state_q, state_d;

   logic [CW-1:0]      count_q;
   logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, operand_q;
   logic               is_div_q, neg_lo_q, neg_hi_q;
   logic               accept, req_div, req_signed, zero_div;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
   logic [2*WIDTH-1:0] prod_neg;

   // Flush beats a new accept; freeze is held low while reset is asserted
   always_comb begin
      accept     = op_valid_in && is_muldiv_op(opcode_in) && !flush;
      req_div    = (opcode_in == OP_DIV) || (opcode_in == OP_DIVS);
      req_signed = is_signed_op(opcode_in);
      zero_div   = req_div && (src2_in == '0);
      mag1       = (req_signed && src1_in[WIDTH-1]) ? -src1_in : src1_in;
      mag2       = (req_signed && src2_in[WIDTH-1]) ? -src2_in : src2_in;
      freeze_out = rest_n && (((state_q == ST_IDLE) && accept) || (state_q == ST_BUSY));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = zero_div ? ST_DONE : ST_BUSY;
         ST_BUSY: begin
            if (flush)               state_d = ST_IDLE;
            else if (count_q == '0)  state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div_q),
      .hi_in   (acc_hi_q),
      .lo_in   (acc_lo_q),
      .operand (operand_q),
      .hi_out  (step_hi),
      .lo_out  (step_lo)
   );

   // Signs are reapplied to the magnitude result of the final iteration
   always_comb begin
      prod_neg = -{step_hi, step_lo};
      fin_hi   = step_hi;
      fin_lo   = step_lo;
      if (is_div_q) begin
         if (neg_lo_q) fin_lo = -step_lo;
         if (neg_hi_q) fin_hi = -step_hi;
      end else if (neg_lo_q) begin
         fin_hi = prod_neg[2*WIDTH-1:WIDTH];
         fin_lo = prod_neg[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         acc_hi_q     <= '0;
         acc_lo_q     <= '0;
         operand_q    <= '0;
         is_div_q     <= 1'b0;
         neg_lo_q     <= 1'b0;
         neg_hi_q     <= 1'b0;
         result_valid <= 1'b0;
         result_lo    <= '0;
         result_hi    <= '0;
         rd_out       <= '0;
         div_by_zero  <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  rd_out      <= rd_in;
                  is_div_q    <= req_div;
                  count_q     <= CW'(WIDTH - 1);
                  acc_hi_q    <= '0;
                  div_by_zero <= 1'b0;
                  neg_lo_q    <= req_signed && (src1_in[WIDTH-1] ^ src2_in[WIDTH-1]);
                  neg_hi_q    <= req_signed && req_div && src1_in[WIDTH-1];
                  acc_lo_q    <= req_div ? mag1 : mag2;
                  operand_q   <= req_div ? mag2 : mag1;
                  if (zero_div) begin
                     result_lo    <= '1;
                     result_hi    <= src1_in;
                     div_by_zero  <= 1'b1;
                     result_valid <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               if (!flush) begin
                  acc_hi_q <= step_hi;
                  acc_lo_q <= step_lo;
                  count_q  <= count_q - 1'b1;
                  if (count_q == '0) begin
                     result_lo    <= fin_lo;
                     result_hi    <= fin_hi;
                     result_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed plan cases plus random ops vs an arithmetic model.
module tb_ex_muldiv_unit;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rest_n;
   logic         flush;
   logic         op_valid_in;
   logic [3:0]   opcode_in;
   logic [W-1:0] src1_in, src2_in, rd_in;
   logic         freeze_out, result_valid, div_by_zero;
   logic [W-1:0] result_lo, result_hi, rd_out;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic [W-1:0] rd;
      logic         dbz;
      int           cycle;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_cnt = 0;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rest_n       (rest_n),
      .flush        (flush),
      .op_valid_in  (op_valid_in),
      .opcode_in    (opcode_in),
      .src1_in      (src1_in),
      .src2_in      (src2_in),
      .rd_in        (rd_in),
      .freeze_out   (freeze_out),
      .result_valid (result_valid),
      .result_lo    (result_lo),
      .result_hi    (result_hi),
      .rd_out       (rd_out),
      .div_by_zero  (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic bit isMulDivModel(input logic [3:0] op);
`ifdef MULDIV_SIGNED_EN
      return op >= 4'hC;
`else
      return (op == 4'hC) || (op == 4'hD);
`endif
   endfunction

   // Reference results straight from integer arithmetic
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, b, rd);
      exp_t        e;
      bit          sgn, div;
      logic [31:0] p;
      int          sa, sb, sq, sr;
      sgn   = (op == 4'hE) || (op == 4'hF);
      div   = (op == 4'hD) || (op == 4'hF);
      e.rd  = rd;
      e.dbz = 1'b0;
      e.cycle = 0;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (div && b == 0) begin
         e.lo  = 16'hFFFF;
         e.hi  = a;
         e.dbz = 1'b1;
      end else if (!div) begin
         if (sgn) p = sa * sb;
         else     p = {16'h0, a} * {16'h0, b};
         e.lo = p[15:0];
         e.hi = p[31:16];
      end else if (sgn) begin
         sq = sa / sb;
         sr = sa % sb;
         e.lo = sq[15:0];
         e.hi = sr[15:0];
      end else begin
         e.lo = a / b;
         e.hi = a % b;
      end
      return e;
   endfunction

   // Monitor: every result strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rest_n === 1'b1 && result_valid === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got result_valid=1 expected 0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = expq.pop_front();
            checkOutput("result_lo", 32'(result_lo), 32'(e.lo));
            checkOutput("result_hi", 32'(result_hi), 32'(e.hi));
            checkOutput("rd_out", 32'(rd_out), 32'(e.rd));
            checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            checkOutput("result_cycle", 32'(cyc_cnt), 32'(e.cycle));
         end
      end
   end

   // abort_kind: 0 none, 1 flush in cycle abort_at, 2 reset in cycle abort_at
   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, b, rd,
                                input int abort_kind, input int abort_at);
      exp_t e;
      bit   md;
      int   stop, fcount, exp_freeze, lat;
      md  = isMulDivModel(op);
      e   = model(op, a, b, rd);
      lat = e.dbz ? 1 : W + 1;
      if (!md)                  stop = 3;
      else if (abort_kind != 0) stop = abort_at;
      else                      stop = lat;
      if (!md)                                       exp_freeze = 0;
      else if (abort_kind == 1 && abort_at == 0)     exp_freeze = 0;
      else if (abort_kind == 1)                      exp_freeze = abort_at + 1;
      else if (abort_kind == 2)                      exp_freeze = abort_at;
      else                                           exp_freeze = lat;
      op_valid_in = 1'b1;
      opcode_in   = op;
      src1_in     = a;
      src2_in     = b;
      rd_in       = rd;
      fcount      = 0;
      for (int c = 0; c <= stop; c++) begin
         if (abort_kind == 1 && c == abort_at) flush = 1'b1;
         if (abort_kind == 2 && c == abort_at) begin
            rest_n = 1'b0;
            #1;
            checkOutput("rst_result_valid", 32'(result_valid), 0);
            checkOutput("rst_result_lo", 32'(result_lo), 0);
            checkOutput("rst_result_hi", 32'(result_hi), 0);
            checkOutput("rst_rd_out", 32'(rd_out), 0);
            checkOutput("rst_div_by_zero", 32'(div_by_zero), 0);
            checkOutput("rst_freeze", 32'(freeze_out), 0);
         end else begin
            #1;
            if (c == 0) begin
               e.cycle = cyc_cnt + lat;
               if (md && abort_kind == 0) expq.push_back(e);
            end
            if (freeze_out === 1'b1) fcount++;
         end
         @(negedge clk);
         flush = 1'b0;
      end
      op_valid_in = 1'b0;
      rest_n      = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         if (freeze_out === 1'b1) fcount++;
         @(negedge clk);
      end
      checkOutput("freeze_cycles", 32'(fcount), 32'(exp_freeze));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rest_n      = 1'b0;
      flush       = 1'b0;
      op_valid_in = 1'b1;
      opcode_in   = 4'hC;
      src1_in     = 16'h1234;
      src2_in     = 16'h0010;
      rd_in       = 16'h0007;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_result_valid", 32'(result_valid), 0);
      checkOutput("reset_result_lo", 32'(result_lo), 0);
      checkOutput("reset_result_hi", 32'(result_hi), 0);
      checkOutput("reset_rd_out", 32'(rd_out), 0);
      checkOutput("reset_div_by_zero", 32'(div_by_zero), 0);
      checkOutput("reset_freeze", 32'(freeze_out), 0);
      @(negedge clk);
      op_valid_in = 1'b0;
      rest_n      = 1'b1;
      @(negedge clk);

      $display("[TB] directed cases");
      applyStimulus(4'hC, 16'h1234, 16'h0010, 16'h0007, 0, 0);
      applyStimulus(4'hD, 16'd100, 16'd7, 16'h0003, 0, 0);
      applyStimulus(4'hD, 16'h0055, 16'h0000, 16'h0009, 0, 0);
      applyStimulus(4'hC, 16'hABCD, 16'h1111, 16'h0001, 1, 5);
      applyStimulus(4'hD, 16'd9, 16'd3, 16'h0002, 0, 0);
      applyStimulus(4'hC, 16'h00FF, 16'h00FF, 16'h0004, 1, 0);
      applyStimulus(4'hD, 16'hBEEF, 16'h0013, 16'h0005, 2, 8);
      applyStimulus(4'hC, 16'd3, 16'd5, 16'h0006, 0, 0);
      applyStimulus(4'hF, 16'hFFF9, 16'h0002, 16'h000A, 0, 0);
      applyStimulus(4'hE, 16'hFFFF, 16'h0002, 16'h000B, 0, 0);
      applyStimulus(4'hF, 16'h8000, 16'hFFFF, 16'h000C, 0, 0);
      applyStimulus(4'hF, 16'hFFF9, 16'h0000, 16'h000D, 0, 0);
      applyStimulus(4'hC, 16'hFFFF, 16'hFFFF, 16'h000E, 0, 0);
      applyStimulus(4'h3, 16'h0011, 16'h0022, 16'h000F, 0, 0);

      $display("[TB] random cases");
      for (int i = 0; i < 40; i++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         case ($urandom_range(0, 4))
            0: op = 4'hC;
            1: op = 4'hD;
            2: op = 4'hE;
            3: op = 4'hF;
            default: op = 4'($urandom_range(0, 11));
         endcase
         a = 16'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 1) == 1) b = b & 16'h00FF;
         applyStimulus(op, a, b, 16'($urandom), 0, 0);
      end

      repeat (3) @(negedge clk);
      checkOutput("pending_results", 32'(expq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative 16-bit multiply/divide unit in the EX stage. It consumes the operands and opcode presented by the ID/EX pipeline register and drives that register's freeze input (and the upstream IF/ID freeze) while an operation is in flight. It returns a one-cycle result pulse to the EX/MEM path. It is the consumer end of the ID/EX interface: the ID/EX register produces and holds, and this block reads and back-pressures.

## Interface
- `WIDTH`, default 16: operand and result width.
- `clk`  in  1: rising-edge clock.
- `rest_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous abort from branch/hazard logic.
- `op_valid_in`  in  1: ID/EX holds a valid instruction (control-word enable bit).
- `opcode_in`  in  4: ID/EX opcode output.
- `src1_in`  in  WIDTH: multiplicand / dividend.
- `src2_in`  in  WIDTH: multiplier / divisor.
- `rd_in`  in  WIDTH: destination field, carried through to the result.
- `freeze_out`  out  1: hold ID/EX and IF/ID.
- `result_valid`  out  1: one-cycle result strobe.
- `result_lo`  out  WIDTH: product low half / quotient.
- `result_hi`  out  WIDTH: product high half / remainder.
- `rd_out`  out  WIDTH: destination latched at accept.
- `div_by_zero`  out  1: valid with `result_valid`.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE, accept condition:** `op_valid_in` is high and `opcode_in` is OP_MUL or OP_DIV.
  - Latch `src1_in`, `src2_in`, `rd_in` and the operation.
  - Load the iteration counter with WIDTH-1.
  - Go to BUSY.
- **MUL:** unsigned shift-add, one bit per cycle. Forms a 2*WIDTH-bit product, returned as {`result_hi`, `result_lo`}.
- **DIV:** unsigned restoring division, one bit per cycle. `result_lo` is the quotient and `result_hi` is the remainder.
- **DIV with `src2_in`==0 at accept:** go directly IDLE->DONE.
  - `result_lo` = all ones.
  - `result_hi` = dividend.
  - `div_by_zero` = 1.
- **BUSY:** counter decrements each cycle. At counter==0 the final step executes and the state goes to DONE.
- **DONE:**
  - `result_valid`=1 for exactly one cycle, then return to IDLE.
  - `opcode_in` is ignored in DONE. ID/EX still shows the completed instruction that cycle and loads the next one at the DONE edge, so a stale re-accept is impossible.
- **`freeze_out`:** combinational, = (IDLE and accept condition) or BUSY. It is low in DONE.
- **Non-muldiv opcodes in IDLE:** ignored, `freeze_out`=0.
- **`flush`:**
  - In BUSY or DONE: return to IDLE next edge with no `result_valid`.
  - In IDLE: flush overrides accept.
- **Reset (`rest_n` low, asynchronous):**
  - state IDLE.
  - `result_valid`, `result_lo`, `result_hi`, `rd_out`, `div_by_zero` = 0.
  - `freeze_out`=0 while reset is held.
  - Reset mid-operation discards all work.
- `result_lo`, `result_hi`, `rd_out` hold their last values outside DONE. `div_by_zero` is cleared on every accept.

## Timing
- Accept in cycle 0 (`freeze_out`=1 combinationally).
- BUSY occupies cycles 1..WIDTH.
- DONE is cycle WIDTH+1.
- `freeze_out` is high for WIDTH+1 cycles (17 at default).
- `result_valid` is high in cycle WIDTH+1.
- Divide-by-zero: `freeze_out` high in cycle 0 only, `result_valid` in cycle 1.
- Back-to-back muldiv: the next accept is no earlier than the cycle after DONE, giving a minimum issue spacing of WIDTH+2 cycles.
- All outputs are registered except `freeze_out`.

## Configuration
- **`MULDIV_SIGNED_EN` defined:** OP_MULS and OP_DIVS are also accepted.
  - Operands are converted to magnitudes at accept and signs are applied when entering DONE.
  - The product is a two's-complement 2*WIDTH-bit result.
  - The quotient truncates toward zero and the remainder takes the dividend's sign.
  - Most-negative ÷ -1 gives quotient = most-negative and remainder = 0, with no flag.
  - Signed divide by zero follows the unsigned rule.
- **Undefined:** OP_MULS and OP_DIVS are treated as non-muldiv opcodes: ignored, with no freeze.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants OP_MUL=4'hC, OP_DIV=4'hD, OP_MULS=4'hE, OP_DIVS=4'hF.
  - State enum.
  - WIDTH default.
- One sub-module, `muldiv_step`: a combinational single-iteration datapath (add-shift or subtract-restore) selected by operation. The top level holds the FSM, counter and registers.

## Test plan
- MUL 0x1234 × 0x0010:
  - `freeze_out` high cycles 0–16.
  - Cycle 17: `result_valid`=1, hi=0x0001, lo=0x2340, `rd_out`=`rd_in`.
  - Stale opcode held in DONE is not re-accepted.
- DIV 100 ÷ 7: cycle 17 gives lo=14 (0x000E), hi=2, `div_by_zero`=0.
- DIV 0x0055 ÷ 0:
  - freeze only in cycle 0.
  - Cycle 1: lo=0xFFFF, hi=0x0055, `div_by_zero`=1.
- MUL accepted, `flush` in cycle 5: IDLE at the next edge, `freeze_out`=0, no `result_valid`. A following DIV 9 ÷ 3 completes with lo=3, hi=0.
- `rest_n` low during cycle 8 of a DIV: all registered outputs 0 and `freeze_out`=0 immediately. After release, a new MUL 3 × 5 completes with lo=15.
- With `MULDIV_SIGNED_EN`:
  - DIVS 0xFFF9 ÷ 0x0002 gives lo=0xFFFD, hi=0xFFFF.
  - MULS 0xFFFF × 0x0002 gives hi=0xFFFF, lo=0xFFFE.
- Without `MULDIV_SIGNED_EN`: opcode 0xE produces no freeze and no result.
